muldiv_sched: RTL
=================

// Module: muldiv_sched
// PURPOSE
//  Sequences the shared multiply unit (fixed latency) and divide unit (start/ready handshake) for the EX stage.
//  Accepts one HI/LO arithmetic op, latches its operands, drives the unit, raises the EX stall request,
//  captures the 64-bit result and holds it until the pipeline advances. Flushes abort in-flight divides.
// PARAMETERS
//  MUL_LAT  1   cycles from operands presented to mul_result valid (>=1)
//  DATA_W   32  operand width; results are 2*DATA_W split into hi/lo
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, synchronous, active-high
//  op_valid    in   1       EX holds a valid instruction
//  op          in   4       one-hot {multu,mult,divu,div}; bit0=div, bit1=divu, bit2=mult, bit3=multu
//  src_a       in   DATA_W  rs value
//  src_b       in   DATA_W  rt value
//  flush       in   1       kill current op
//  ex_advance  in   1       EX->MEM transfer this cycle
//  stallreq    out  1       stall pipeline at EX
//  res_valid   out  1       res_hi/res_lo valid for HI/LO write
//  res_hi      out  DATA_W  result high word (div: remainder)
//  res_lo      out  DATA_W  result low word (div: quotient)
//  mul_signed  out  1       to mul unit
//  mul_opa     out  DATA_W  to mul unit
//  mul_opb     out  DATA_W  to mul unit
//  mul_result  in   2*DATA_W from mul unit
//  div_start   out  1       level start to divider
//  div_signed  out  1       to divider
//  div_opa     out  DATA_W  dividend
//  div_opb     out  DATA_W  divisor
//  div_annul   out  1       abort divider
//  div_ready   in   1       divider result valid (single cycle)
//  div_result  in   2*DATA_W {remainder,quotient}
// BEHAVIOUR
//  States IDLE, MUL, DIV, DONE. Reset: IDLE; all outputs 0; result and operand regs 0.
//  IDLE: accepts when op_valid and op is exactly one-hot. Operands and signedness are latched.
//   stallreq=1 combinationally in the accept cycle T0.
//   Non-one-hot or zero op: ignored and remains IDLE.
//  Operand mux: unit operands = src_a/src_b in IDLE, otherwise the latched copies.
//  MUL: count 0..MUL_LAT. At count==MUL_LAT, mul_result is loaded into the result regs and the block enters DONE.
//   stallreq=1 from T0 to T0+MUL_LAT; DONE occurs at T0+MUL_LAT+1.
//  DIV, divisor!=0: div_start=1 from T0 until the cycle div_ready=1 (inclusive of T0, exclusive of the ready cycle).
//   On div_ready, div_result is loaded and the block enters DONE the next cycle; stallreq=1 until DONE.
//  DIV, divisor==0: div_start is never raised. DONE at T0+1 with res_hi=res_lo=0.
//  DONE: res_valid=1, stallreq=0, result regs held. On ex_advance go to IDLE.
//   No re-accept while in DONE even if op_valid stays high (EX held by a downstream stall).
//  flush: highest priority after rst. In any state, go to IDLE next cycle and clear res_valid.
//   div_annul=1 (combinational) in that cycle only if the state is DIV; stallreq=0 in the flush cycle.
//   A div_ready arriving in the same cycle as flush is discarded.
//  Reset mid-operation behaves as flush; no annul is needed because the divider shares rst.
//  div_ready outside DIV is ignored (assertion).
// STRUCTURE
//  lib/defines.vh: MULDIV_ST_* state encodings, MULDIV_OP_DIV/DIVU/MULT/MULTU bit indices, MULDIV_OP_W=4.
//  Single module; the MUL latency counter is inline ($clog2(MUL_LAT+1) bits). No sub-module.
// TESTING
//  mult src_a=-3, src_b=7, MUL_LAT=1 -> stallreq high 2 cycles; DONE at T0+2: res_hi=FFFFFFFF, res_lo=FFFFFFEB.
//  divu 100/7 with 32-cycle divider model -> div_start held until ready; then res_lo=14, res_hi=2, stallreq drops the same cycle as DONE.
//  div src_b=0 -> div_start never 1; DONE at T0+1 with res_hi=res_lo=0.
//  flush at cycle 10 of a div -> div_annul=1 for one cycle, IDLE next cycle, res_valid stays 0.
//   A new mult next cycle is accepted normally.
//  DONE with ex_advance=0 for 3 cycles and op_valid=1 -> result stable, no restart.
//   ex_advance=1 -> IDLE; op=4'b0101 then ignored with stallreq=0.

Source files
------------

// File: rtl/muldiv_sched_pkg.sv
// muldiv_sched_pkg
//   Shared definitions for the EX-stage multiply/divide sequencer:
//   the sequencer state encoding, the bit positions of the one-hot
//   HI/LO opcode, and a helper that checks an opcode is exactly one-hot.
package muldiv_sched_pkg;

    localparam int OP_W     = 4;
    localparam int OP_DIV   = 0;
    localparam int OP_DIVU  = 1;
    localparam int OP_MULT  = 2;
    localparam int OP_MULTU = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Exactly one bit set; zero and multi-bit codes are rejected.
    function automatic logic is_onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - OP_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/muldiv_sched.sv
// muldiv_sched
//   Sequences the shared fixed-latency multiplier and the handshaked
//   divider for the EX stage. One HI/LO op is accepted from IDLE, its
//   operands are latched, the unit is driven, EX is stalled, and the
//   64-bit result is held in DONE until the pipeline advances. A flush
//   aborts any op in flight and annuls a running divide.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   op_valid, op        EX instruction valid, one-hot {multu,mult,divu,div}
//   src_a, src_b        rs / rt operand values
//   flush, ex_advance   kill current op / EX->MEM transfer this cycle
//   stallreq            stall request to the pipeline
//   res_valid, res_hi,  result valid and {hi,lo} words
//   res_lo              (div: hi=remainder, lo=quotient)
//   mul_*               multiplier operands / signedness / product
//   div_*               divider start, signedness, operands, annul,
//                       ready pulse and {remainder,quotient} result
module muldiv_sched
    import muldiv_sched_pkg::*;
#(
    parameter int MUL_LAT = 1,
    parameter int DATA_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic [OP_W-1:0]       op,
    input  logic [DATA_W-1:0]     src_a,
    input  logic [DATA_W-1:0]     src_b,
    input  logic                  flush,
    input  logic                  ex_advance,
    output logic                  stallreq,
    output logic                  res_valid,
    output logic [DATA_W-1:0]     res_hi,
    output logic [DATA_W-1:0]     res_lo,
    output logic                  mul_signed,
    output logic [DATA_W-1:0]     mul_opa,
    output logic [DATA_W-1:0]     mul_opb,
    input  logic [2*DATA_W-1:0]   mul_result,
    output logic                  div_start,
    output logic                  div_signed,
    output logic [DATA_W-1:0]     div_opa,
    output logic [DATA_W-1:0]     div_opb,
    output logic                  div_annul,
    input  logic                  div_ready,
    input  logic [2*DATA_W-1:0]   div_result
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    state_t              state;
    state_t              state_next;
    logic [CNT_W-1:0]    mul_cnt;
    logic [DATA_W-1:0]   opa_q;
    logic [DATA_W-1:0]   opb_q;
    logic                signed_q;

    logic                accept;
    logic                op_is_mul;
    logic                op_signed;
    logic                latch_ops;
    logic                load_mul;
    logic                load_div;
    logic                load_zero;

    assign accept    = (state == ST_IDLE) && op_valid && is_onehot(op);
    assign op_is_mul = op[OP_MULT] | op[OP_MULTU];
    assign op_signed = op[OP_MULT] | op[OP_DIV];

    // In IDLE the units see the live operands so the multiplier can start
    // in the accept cycle; afterwards they see the latched copies so EX
    // may change its inputs freely.
    assign mul_opa    = (state == ST_IDLE) ? src_a : opa_q;
    assign mul_opb    = (state == ST_IDLE) ? src_b : opb_q;
    assign div_opa    = (state == ST_IDLE) ? src_a : opa_q;
    assign div_opb    = (state == ST_IDLE) ? src_b : opb_q;
    assign mul_signed = (state == ST_IDLE) ? op_signed : signed_q;
    assign div_signed = (state == ST_IDLE) ? op_signed : signed_q;
    assign res_valid  = (state == ST_DONE);

    // Next-state and handshake decode. Reset and flush both force IDLE;
    // flush only annuls the divider when one is actually running, and a
    // div_ready coinciding with flush is dropped because no load fires.
    // A zero divisor never touches the divider and completes immediately
    // with a zero result.
    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        div_start  = 1'b0;
        div_annul  = 1'b0;
        latch_ops  = 1'b0;
        load_mul   = 1'b0;
        load_div   = 1'b0;
        load_zero  = 1'b0;
        if (rst) begin
            state_next = ST_IDLE;
        end else if (flush) begin
            state_next = ST_IDLE;
            div_annul  = (state == ST_DIV);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        stallreq  = 1'b1;
                        latch_ops = 1'b1;
                        if (op_is_mul) begin
                            state_next = ST_MUL;
                        end else if (src_b == '0) begin
                            state_next = ST_DONE;
                            load_zero  = 1'b1;
                        end else begin
                            state_next = ST_DIV;
                            div_start  = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    stallreq = 1'b1;
                    if (mul_cnt == CNT_W'(MUL_LAT)) begin
                        state_next = ST_DONE;
                        load_mul   = 1'b1;
                    end
                end
                ST_DIV: begin
                    stallreq = 1'b1;
                    if (div_ready) begin
                        state_next = ST_DONE;
                        load_div   = 1'b1;
                    end else begin
                        div_start = 1'b1;
                    end
                end
                ST_DONE: begin
                    if (ex_advance) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State, operand latches, latency counter and result registers.
    // The counter starts at 1 on entry to MUL because the accept cycle
    // itself is count 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            mul_cnt  <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            signed_q <= 1'b0;
            res_hi   <= '0;
            res_lo   <= '0;
        end else begin
            state <= state_next;
            if (latch_ops) begin
                opa_q    <= src_a;
                opb_q    <= src_b;
                signed_q <= op_signed;
                mul_cnt  <= CNT_W'(1);
            end else if (state == ST_MUL) begin
                mul_cnt <= mul_cnt + CNT_W'(1);
            end
            if (load_mul) begin
                {res_hi, res_lo} <= mul_result;
            end else if (load_div) begin
                {res_hi, res_lo} <= div_result;
            end else if (load_zero) begin
                res_hi <= '0;
                res_lo <= '0;
            end
        end
    end

    // The divider must only report completion while a divide is running.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(div_ready && (state != ST_DIV)));
        end
    end

endmodule
